// File: rtl/mor1kx_cfgrs_arbiter.sv
// Two-port (CPU / debug unit) arbiter for the read-only configuration SPR bank.
// Round-robin grant, group-0 decode, fixed 3-cycle IDLE/ACCESS/RESP transaction.
module mor1kx_cfgrs_arbiter #(
    parameter FEATURE_DEBUGUNIT = "NONE",
    parameter OPTION_WRITE_ERR  = "ENABLED",
    parameter int OPTION_CFG_REGS = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [32*OPTION_CFG_REGS-1:0] cfg_flat_i,
    input  logic                          cpu_req_i,
    input  logic                          cpu_we_i,
    input  logic [15:0]                   cpu_addr_i,
    output logic                          cpu_ack_o,
    output logic                          cpu_err_o,
    output logic [31:0]                   cpu_dat_o,
    input  logic                          du_req_i,
    input  logic                          du_we_i,
    input  logic [15:0]                   du_addr_i,
    output logic                          du_ack_o,
    output logic                          du_err_o,
    output logic [31:0]                   du_dat_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DU  = 1'b1;

    localparam bit DU_EN  = (FEATURE_DEBUGUNIT == "ENABLED");
    localparam bit WR_ERR = (OPTION_WRITE_ERR == "ENABLED");

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
    } spr_req_t;

    logic [1:0] state;
    logic       grant;
    logic       last_grant;
    spr_req_t   req_q;

    logic        du_req;
    logic        nxt_grant;
    logic        hit;
    logic [31:0] rd_word;
    logic [31:0] nxt_dat;
    logic        nxt_err;

    assign du_req = DU_EN && du_req_i;

    // Contention goes to whichever port did not win last time.
    always_comb begin
        nxt_grant = GNT_CPU;
        if (cpu_req_i && du_req)
            nxt_grant = (last_grant == GNT_DU) ? GNT_CPU : GNT_DU;
        else if (du_req)
            nxt_grant = GNT_DU;
    end

    always_comb begin
        hit     = (req_q.addr[15:11] == 5'd0) &&
                  (req_q.addr[10:0] < 11'(OPTION_CFG_REGS));
        rd_word = '0;
        for (int k = 0; k < OPTION_CFG_REGS; k++)
            if (req_q.addr[10:0] == 11'(k))
                rd_word = cfg_flat_i[32*k +: 32];
        nxt_dat = '0;
        nxt_err = 1'b1;
        if (hit) begin
            nxt_err = req_q.we ? 1'(WR_ERR) : 1'b0;
            nxt_dat = req_q.we ? 32'd0 : rd_word;
        end
    end

    // The response is registered straight into the granted port's outputs at
    // the end of ACCESS, so those flops are high exactly while in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= GNT_CPU;
            last_grant <= GNT_DU;
            req_q      <= '0;
            cpu_ack_o  <= 1'b0;
            cpu_err_o  <= 1'b0;
            cpu_dat_o  <= '0;
            du_ack_o   <= 1'b0;
            du_err_o   <= 1'b0;
            du_dat_o   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req_i || du_req) begin
                        grant <= nxt_grant;
                        req_q <= (nxt_grant == GNT_DU) ? spr_req_t'({du_we_i, du_addr_i})
                                                       : spr_req_t'({cpu_we_i, cpu_addr_i});
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (grant == GNT_CPU) begin
                        cpu_ack_o <= 1'b1;
                        cpu_err_o <= nxt_err;
                        cpu_dat_o <= nxt_dat;
                    end else begin
                        du_ack_o <= 1'b1;
                        du_err_o <= nxt_err;
                        du_dat_o <= nxt_dat;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    cpu_ack_o  <= 1'b0;
                    cpu_err_o  <= 1'b0;
                    cpu_dat_o  <= '0;
                    du_ack_o   <= 1'b0;
                    du_err_o   <= 1'b0;
                    du_dat_o   <= '0;
                    last_grant <= grant;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mor1kx_cfgrs_arbiter.sv
// Scoreboard bench: requester tasks push expected responses, a negedge monitor
// pops and compares on every ack. Three instances cover the parameter variants.
module tb_mor1kx_cfgrs_arbiter;

    localparam int NREG = 11;
    localparam logic [31:0] CFG_W [NREG] = '{
        32'h1200_0000, 32'h0000_0701, 32'h0000_0020, 32'h0000_0028,
        32'h0000_0030, 32'h0000_0041, 32'h0000_0051, 32'h0000_0302,
        32'h0000_0003, 32'h0A0B_0C0D, 32'h0102_0300 };

    typedef struct {
        logic        err;
        logic [31:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [32*NREG-1:0] cfg_flat;

    // shared stimulus for instances a (write err on) and b (write err off)
    logic        cpu_req, cpu_we, du_req, du_we;
    logic [15:0] cpu_addr, du_addr;
    logic        a_cpu_ack, a_cpu_err, a_du_ack, a_du_err;
    logic [31:0] a_cpu_dat, a_du_dat;
    logic        b_cpu_ack, b_cpu_err, b_du_ack, b_du_err;
    logic [31:0] b_cpu_dat, b_du_dat;
    // instance c: debug unit disabled
    logic        c_cpu_req, c_cpu_we, c_du_req, c_du_we;
    logic [15:0] c_cpu_addr, c_du_addr;
    logic        c_cpu_ack, c_cpu_err, c_du_ack, c_du_err;
    logic [31:0] c_cpu_dat, c_du_dat;

    exp_t qa_cpu[$], qa_du[$], qb_cpu[$], qb_du[$], qc_cpu[$];
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mor1kx_cfgrs_arbiter #(.FEATURE_DEBUGUNIT("ENABLED"), .OPTION_WRITE_ERR("ENABLED"),
                           .OPTION_CFG_REGS(NREG)) dut_a (
        .clk(clk), .rst(rst), .cfg_flat_i(cfg_flat),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_ack_o(a_cpu_ack), .cpu_err_o(a_cpu_err), .cpu_dat_o(a_cpu_dat),
        .du_req_i(du_req), .du_we_i(du_we), .du_addr_i(du_addr),
        .du_ack_o(a_du_ack), .du_err_o(a_du_err), .du_dat_o(a_du_dat));

    mor1kx_cfgrs_arbiter #(.FEATURE_DEBUGUNIT("ENABLED"), .OPTION_WRITE_ERR("NONE"),
                           .OPTION_CFG_REGS(NREG)) dut_b (
        .clk(clk), .rst(rst), .cfg_flat_i(cfg_flat),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_ack_o(b_cpu_ack), .cpu_err_o(b_cpu_err), .cpu_dat_o(b_cpu_dat),
        .du_req_i(du_req), .du_we_i(du_we), .du_addr_i(du_addr),
        .du_ack_o(b_du_ack), .du_err_o(b_du_err), .du_dat_o(b_du_dat));

    mor1kx_cfgrs_arbiter #(.FEATURE_DEBUGUNIT("NONE"), .OPTION_WRITE_ERR("ENABLED"),
                           .OPTION_CFG_REGS(NREG)) dut_c (
        .clk(clk), .rst(rst), .cfg_flat_i(cfg_flat),
        .cpu_req_i(c_cpu_req), .cpu_we_i(c_cpu_we), .cpu_addr_i(c_cpu_addr),
        .cpu_ack_o(c_cpu_ack), .cpu_err_o(c_cpu_err), .cpu_dat_o(c_cpu_dat),
        .du_req_i(c_du_req), .du_we_i(c_du_we), .du_addr_i(c_du_addr),
        .du_ack_o(c_du_ack), .du_err_o(c_du_err), .du_dat_o(c_du_dat));

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic cmp_resp(input string nm, input exp_t e, input logic err, input logic [31:0] dat);
        chk(nm, 64'({err, dat}), 64'({e.err, e.dat}));
    endtask

    // monitor: pops one expectation per ack, checks idle outputs stay 0
    always @(negedge clk) begin
        if (a_cpu_ack) begin
            chk("a_cpu_expected", 64'(qa_cpu.size() != 0), 64'd1);
            if (qa_cpu.size() != 0) cmp_resp("a_cpu_resp", qa_cpu.pop_front(), a_cpu_err, a_cpu_dat);
        end else chk("a_cpu_idle", 64'({a_cpu_err, a_cpu_dat}), 64'd0);
        if (a_du_ack) begin
            chk("a_du_expected", 64'(qa_du.size() != 0), 64'd1);
            if (qa_du.size() != 0) cmp_resp("a_du_resp", qa_du.pop_front(), a_du_err, a_du_dat);
        end else chk("a_du_idle", 64'({a_du_err, a_du_dat}), 64'd0);
        if (b_cpu_ack) begin
            chk("b_cpu_expected", 64'(qb_cpu.size() != 0), 64'd1);
            if (qb_cpu.size() != 0) cmp_resp("b_cpu_resp", qb_cpu.pop_front(), b_cpu_err, b_cpu_dat);
        end else chk("b_cpu_idle", 64'({b_cpu_err, b_cpu_dat}), 64'd0);
        if (b_du_ack) begin
            chk("b_du_expected", 64'(qb_du.size() != 0), 64'd1);
            if (qb_du.size() != 0) cmp_resp("b_du_resp", qb_du.pop_front(), b_du_err, b_du_dat);
        end else chk("b_du_idle", 64'({b_du_err, b_du_dat}), 64'd0);
        if (c_cpu_ack) begin
            chk("c_cpu_expected", 64'(qc_cpu.size() != 0), 64'd1);
            if (qc_cpu.size() != 0) cmp_resp("c_cpu_resp", qc_cpu.pop_front(), c_cpu_err, c_cpu_dat);
        end else chk("c_cpu_idle", 64'({c_cpu_err, c_cpu_dat}), 64'd0);
        chk("c_du_silent", 64'({c_du_ack, c_du_err, c_du_dat}), 64'd0);
    end

    // Each requester task starts 1 time unit after a rising edge; lat is the
    // number of rising edges until ack is visible.
    task automatic cpu_ab(input logic we, input logic [15:0] addr, input logic [31:0] ed,
                          input logic ea, input logic eb, input int lat);
        int n;
        exp_t e;
        e.dat = ed; e.err = ea; qa_cpu.push_back(e);
        e.err = eb; qb_cpu.push_back(e);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!a_cpu_ack && n < 20);
        chk("cpu_latency", 64'(n), 64'(lat));
        chk("cpu_ack_ab", 64'({a_cpu_ack, b_cpu_ack}), 64'd3);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    endtask

    task automatic du_ab(input logic we, input logic [15:0] addr, input logic [31:0] ed,
                         input logic ea, input logic eb, input int lat);
        int n;
        exp_t e;
        e.dat = ed; e.err = ea; qa_du.push_back(e);
        e.err = eb; qb_du.push_back(e);
        du_req = 1'b1; du_we = we; du_addr = addr;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!a_du_ack && n < 20);
        chk("du_latency", 64'(n), 64'(lat));
        chk("du_ack_ab", 64'({a_du_ack, b_du_ack}), 64'd3);
        @(posedge clk); #1;
        du_req = 1'b0; du_we = 1'b0; du_addr = '0;
    endtask

    task automatic cpu_c(input logic we, input logic [15:0] addr, input logic [31:0] ed,
                         input logic ee, input int lat);
        int n;
        exp_t e;
        e.dat = ed; e.err = ee; qc_cpu.push_back(e);
        c_cpu_req = 1'b1; c_cpu_we = we; c_cpu_addr = addr;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!c_cpu_ack && n < 20);
        chk("c_cpu_latency", 64'(n), 64'(lat));
        @(posedge clk); #1;
        c_cpu_req = 1'b0; c_cpu_we = 1'b0; c_cpu_addr = '0;
    endtask

    initial begin
        for (int k = 0; k < NREG; k++) cfg_flat[32*k +: 32] = CFG_W[k];
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        du_req = 1'b0; du_we = 1'b0; du_addr = '0;
        c_cpu_req = 1'b0; c_cpu_we = 1'b0; c_cpu_addr = '0;
        c_du_req = 1'b1; c_du_we = 1'b0; c_du_addr = 16'h0001;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a", 64'({a_cpu_ack, a_cpu_err, a_cpu_dat, a_du_ack, a_du_err}), 64'd0);
        chk("rst_b", 64'({b_cpu_ack, b_cpu_err, b_cpu_dat, b_du_ack, b_du_err}), 64'd0);
        chk("rst_dat", 64'({a_du_dat, b_du_dat}), 64'd0);
        chk("rst_c", 64'({c_cpu_ack, c_cpu_err, c_cpu_dat}), 64'd0);
        rst = 1'b0;

        // contention from the first cycle after reset: CPU first, DU three later
        fork
            cpu_ab(1'b0, 16'h0000, CFG_W[0], 1'b0, 1'b0, 2);
            du_ab(1'b0, 16'h000A, CFG_W[10], 1'b0, 1'b0, 5);
        join
        // continuous contention alternates CPU, DU, CPU, DU
        fork
            begin
                cpu_ab(1'b0, 16'h0001, CFG_W[1], 1'b0, 1'b0, 2);
                cpu_ab(1'b0, 16'h0002, CFG_W[2], 1'b0, 1'b0, 5);
            end
            begin
                du_ab(1'b0, 16'h0003, CFG_W[3], 1'b0, 1'b0, 5);
                du_ab(1'b0, 16'h0004, CFG_W[4], 1'b0, 1'b0, 5);
            end
        join

        // decode misses, writes, read-back
        cpu_ab(1'b0, 16'h0800, 32'd0, 1'b1, 1'b1, 2);
        cpu_ab(1'b0, 16'h000B, 32'd0, 1'b1, 1'b1, 2);
        cpu_ab(1'b1, 16'h0002, 32'd0, 1'b1, 1'b0, 2);
        cpu_ab(1'b0, 16'h0002, CFG_W[2], 1'b0, 1'b0, 2);
        cpu_ab(1'b0, 16'h0001, CFG_W[1], 1'b0, 1'b0, 2);
        du_ab(1'b1, 16'h1234, 32'd0, 1'b1, 1'b1, 2);
        du_ab(1'b0, 16'h0007, CFG_W[7], 1'b0, 1'b0, 2);

        // debug unit disabled: held du_req never delays the CPU
        cpu_c(1'b0, 16'h0009, CFG_W[9], 1'b0, 2);
        cpu_c(1'b1, 16'h0005, 32'd0, 1'b1, 2);
        cpu_c(1'b0, 16'h0003, CFG_W[3], 1'b0, 2);

        // reset while the CPU read is in ACCESS drops the transaction
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_a", 64'({a_cpu_ack, a_cpu_err, a_cpu_dat, a_du_ack}), 64'd0);
        chk("midrst_b", 64'({b_cpu_ack, b_cpu_err, b_cpu_dat, b_du_ack}), 64'd0);
        @(posedge clk); #1;
        chk("midrst_hold", 64'({a_cpu_ack, b_cpu_ack, a_cpu_dat}), 64'd0);
        rst = 1'b0;
        cpu_ab(1'b0, 16'h0001, CFG_W[1], 1'b0, 1'b0, 2);

        repeat (4) @(posedge clk);
        #1;
        chk("qa_cpu_drained", 64'(qa_cpu.size()), 64'd0);
        chk("qa_du_drained", 64'(qa_du.size()), 64'd0);
        chk("qb_cpu_drained", 64'(qb_cpu.size()), 64'd0);
        chk("qb_du_drained", 64'(qb_du.size()), 64'd0);
        chk("qc_cpu_drained", 64'(qc_cpu.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mor1kx_cfgrs_arbiter.md
Name: mor1kx_cfgrs_arbiter

Overview:
- Shares the read-only configuration SPR bank (VR, UPR, CPUCFGR, DMMUCFGR, IMMUCFGR, DCCFGR, ICCFGR, DCFGR, PCCFGR, VR2, AVR) between two requesters: the CPU control stage and the debug unit.
- Each access is a registered, fixed-latency req/ack transaction. The block does round-robin arbitration, decodes group 0 addresses, and returns a registered result.
- It sits between the configuration register bank outputs and the CPU's SPR read mux.

Parameters:
FEATURE_DEBUGUNIT, "NONE", "ENABLED" = DU port is arbitrated; "NONE" = DU port is never granted and du_ack/du_err/du_dat are held at 0.
OPTION_WRITE_ERR, "ENABLED", "ENABLED" = a write to a mapped config SPR returns err=1; "NONE" = the write is acked silently.
OPTION_CFG_REGS, 11, number of mapped config SPRs, at group-0 indices 0..OPTION_CFG_REGS-1.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cfg_flat_i  in  32*OPTION_CFG_REGS  config SPR values; word k at bits [32k+31:32k]; order VR, UPR, CPUCFGR, DMMUCFGR, IMMUCFGR, DCCFGR, ICCFGR, DCFGR, PCCFGR, VR2, AVR
cpu_req_i  in  1  CPU access request, held until ack
cpu_we_i  in  1  CPU write enable
cpu_addr_i  in  16  CPU SPR address
cpu_ack_o  out  1  one-cycle completion pulse
cpu_err_o  out  1  error, valid with ack
cpu_dat_o  out  32  read data, valid with ack
du_req_i  in  1  DU access request, held until ack
du_we_i  in  1  DU write enable
du_addr_i  in  16  DU SPR address
du_ack_o  out  1  one-cycle completion pulse
du_err_o  out  1  error, valid with ack
du_dat_o  out  32  read data, valid with ack

Behaviour:
- Single clock clk. Reset rst is asynchronous and active-high. All state is in flops cleared on posedge rst.
- Reset values:
  - all ack, err and dat outputs = 0
  - FSM = IDLE
  - last_grant = DU, so the CPU wins the first contention
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any enabled req is high, latch the grant, addr and we, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: decode the latched addr, sample cfg_flat_i, register data and err into the response regs, then go to RESP.
  - RESP: drive the granted port's ack=1 with dat/err for exactly one cycle, update last_grant to the granted port, then go to IDLE.
- Latency and throughput:
  - req high at IDLE edge N gives ack during cycle N+2.
  - Maximum throughput is one transaction per 3 cycles.
- Arbitration:
  - Only one requester high: that requester is granted.
  - Both high: the port that is not last_grant is granted, so back-to-back contention alternates CPU, DU, CPU, ...
  - The loser keeps req high and is served in the next transaction.
- Handshake rules:
  - The requester holds req, we and addr stable until it sees ack.
  - It deasserts req in the cycle after ack, unless it is issuing a new access.
  - The arbiter ignores req, we and addr changes in ACCESS and RESP.
  - If req drops mid-transaction, the transaction still completes and ack still pulses; the requester ignores it.
- Decode:
  - A hit requires addr[15:11]==0 and addr[10:0] < OPTION_CFG_REGS.
  - Read hit: dat = word addr[10:0], err=0.
  - Read miss (other group or unmapped index): dat=0, err=1.
  - Write hit: dat=0, err=(OPTION_WRITE_ERR=="ENABLED"). No state changes.
  - Write miss: dat=0, err=1.
- Output rules:
  - The non-granted port's ack, err and dat stay 0 at all times.
  - dat and err outputs are 0 in every cycle where ack=0.
- FEATURE_DEBUGUNIT="NONE": du_req_i is ignored entirely and the CPU never waits on it.
- Reset mid-transaction: the FSM immediately returns to IDLE and any pending ack is dropped. The requester must reissue its access after reset.

Test Plan:
- CPU reads addr 0x0001 (UPR) with cfg UPR=0x0000_0701 -> cpu_ack_o=1 two cycles after req, cpu_dat_o=0x0000_0701, cpu_err_o=0, du_ack_o=0 throughout.
- CPU and DU both request from the first cycle after reset, CPU addr 0x0000 and DU addr 0x000A, each dropping req after its ack -> CPU acked at cycle 2 with VR, DU acked at cycle 5 with AVR. Repeat continuous contention -> grants alternate CPU, DU, CPU, DU.
- CPU reads 0x0800 (group 1), then 0x000B (unmapped index) -> both give ack with err=1 and dat=0.
- CPU writes 0x0002 with OPTION_WRITE_ERR="ENABLED" -> ack with err=1. Repeat with "NONE" -> ack with err=0. A subsequent read of 0x0002 returns the unchanged CPUCFGR.
- FEATURE_DEBUGUNIT="NONE", du_req_i held high while the CPU reads 0x0009 -> du_ack_o never asserts and the CPU is served at its normal 2-cycle latency.
- Assert rst during ACCESS of a CPU read -> no ack issued, FSM in IDLE, all outputs 0. After rst deasserts, the held req is served within 2 cycles.
